pwm_width_capture: RTL and testbench
====================================

Name: pwm_width_capture

Overview:
- Multi-channel, synthesizable version of the pulse-width measurement used around the delta-sigma DAC.
- Each channel counts the high cycles of its PWM/DS output bit. The counting window is delimited by transitions of that channel's pulse-toggle signal.
- Completed window counts are queued per channel. A round-robin arbiter presents them on a single valid/ready stream.
- The block sits beside the modulator. It feeds on-chip self-test and the register readback path.

Parameters:
- CHANNELS, 2, number of independent pwm/toggle channel pairs (1..8).
- CNT_BITS, 16, width of the per-window high-cycle counter and of the output result.
- CH_BITS, $clog2(CHANNELS) min 1, width of the channel index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  count enable. When low, counters hold and no captures occur.
- pwm_in  in  CHANNELS  PWM/DS bit per channel, synchronous to clk.
- toggle_in  in  CHANNELS  pulse-toggle per channel. Any level change ends the current window.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_chan  out  CH_BITS  channel index of the result.
- out_width  out  CNT_BITS  high-cycle count of the completed window.
- out_sat  out  1  the window count saturated.
- overrun  out  CHANNELS  sticky flag: an unread capture was overwritten.
- clear_overrun  in  1  clears all overrun bits.

Behaviour:
Reset (rst_n=0 at a clk edge)
- All registers clear: last_tog=0, tog_evt=0, acc=0, sat=0, armed=0, pending=0, hold=0, out_valid=0, out_chan=0, out_width=0, out_sat=0, overrun=0, rr_ptr=0.
- Reset mid-window discards all state. Nothing is emitted for the interrupted window.

Per-channel edge detection (always active, including when en=0)
- last_tog <= toggle_in.
- tog_evt <= (toggle_in != last_tog).
- A toggle change on cycle T therefore produces tog_evt=1 on cycle T+1.

Per-channel accumulator (en=1)
- tog_evt=0: acc <= min(acc + pwm_in, 2^CNT_BITS-1). sat <= sat | (acc == max && pwm_in).
- tog_evt=1: capture {acc, sat} into hold, then restart with acc <= pwm_in and sat <= 0.
- The first tog_evt after reset only sets armed=1; its capture is discarded as a partial window.
- Only captures with armed=1 set pending.
- en=0: acc, sat and armed hold. A tog_evt occurring while en=0 is lost; no capture.

Pending / overrun
- A capture while pending=1 overwrites hold and sets overrun[ch]. This applies unless the arbiter takes that channel's hold in the same cycle; in that case there is no overrun and pending stays 1 for the new data.
- clear_overrun=1 clears overrun. A simultaneous new overrun event wins, so the bit stays 1.

Output stage
- Single output register with valid/ready handshake.
- Load when !out_valid || out_ready.
- Source: first pending channel searching from rr_ptr upward, wrapping modulo CHANNELS.
- On load: out_valid=1, out_chan/out_width/out_sat from that channel, pending[ch] cleared, rr_ptr <= ch+1 (wraps).
- No pending channel at load time: out_valid <= 0.
- While out_valid && !out_ready, all outputs are stable.
- Latency: toggle change at T, tog_evt at T+1, hold/pending at T+2, out_valid at T+3 (output register empty).
- Back-to-back: one result per cycle while out_ready=1.

Optional Feature:
- Macro PWM_CAPTURE_PERIOD_EN.
- When defined:
  - Each channel also counts window length in clk cycles (en=1 cycles only), saturating at 2^CNT_BITS-1.
  - Extra output port out_period [CNT_BITS] is captured and queued alongside out_width, with identical timing.
  - out_sat is set if either count saturated.
- When undefined: the out_period port and its counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, CHANNELS=2, ch0 pwm_in high 5 of every 8 cycles, toggle_in[0] flips every 8 cycles -> first window discarded. Each subsequent result: out_chan=0, out_width=5, out_sat=0. out_valid first rises 3 cycles after the second toggle change.
2. CNT_BITS=4, pwm_in[0]=1 constant, toggle every 20 cycles -> out_width=15, out_sat=1. Next window of 10 cycles -> out_width=10, out_sat=0.
3. Both channels toggle on the same cycle, out_ready=1 -> ch0 result, then ch1 result next cycle. Repeat -> rr order gives ch0 then ch1 again (rr_ptr wrapped to 0).
4. out_ready=0 held for 3 windows on ch0 -> out_valid=1 with the first result stable throughout. overrun[0]=1. After out_ready=1: first result, then the latest window only. clear_overrun -> overrun=0.
5. en=0 across a toggle change, pwm_in=1 -> no result. acc holds. After en=1 the next window's count includes pre-disable cycles plus post-enable cycles.
6. rst_n=0 asserted mid-window with pending data and out_valid=1 -> next cycle all outputs 0. The first toggle after release is discarded.

Source files
------------

// File: rtl/pwm_width_capture.sv
// Multi-channel PWM high-cycle window capture with a round-robin valid/ready result stream.
// Optional macro PWM_CAPTURE_PERIOD_EN adds a per-window period count on out_period.
`timescale 1ns/1ps

module pwm_width_capture #(
    parameter int CHANNELS = 2,
    parameter int CNT_BITS = 16,
    parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] pwm_in,
    input  logic [CHANNELS-1:0] toggle_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_BITS-1:0]  out_chan,
    output logic [CNT_BITS-1:0] out_width,
    output logic                out_sat,
`ifdef PWM_CAPTURE_PERIOD_EN
    output logic [CNT_BITS-1:0] out_period,
`endif
    output logic [CHANNELS-1:0] overrun,
    input  logic                clear_overrun
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CH_BITS:0]    CH_CNT  = (CH_BITS+1)'(CHANNELS);

    logic [CHANNELS-1:0] r_last_tog;
    logic [CHANNELS-1:0] r_tog_evt;
    logic [CHANNELS-1:0] r_sat;
    logic [CHANNELS-1:0] r_armed;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_hold_sat;
    logic [CHANNELS-1:0] r_overrun;
    logic [CNT_BITS-1:0] r_acc    [CHANNELS];
    logic [CNT_BITS-1:0] r_hold_w [CHANNELS];
`ifdef PWM_CAPTURE_PERIOD_EN
    logic [CHANNELS-1:0] r_per_sat;
    logic [CNT_BITS-1:0] r_per    [CHANNELS];
    logic [CNT_BITS-1:0] r_hold_p [CHANNELS];
    logic [CNT_BITS-1:0] r_out_period;
`endif

    logic                r_out_valid;
    logic [CH_BITS-1:0]  r_out_chan;
    logic [CNT_BITS-1:0] r_out_width;
    logic                r_out_sat;
    logic [CH_BITS-1:0]  r_rr_ptr;

    logic [CHANNELS-1:0] w_capture;
    logic [CHANNELS-1:0] w_take;
    logic [CHANNELS-1:0] w_rot;
    logic                w_load;
    logic                w_found;
    logic [CH_BITS-1:0]  w_off;
    logic [CH_BITS:0]    w_sum;
    logic [CH_BITS:0]    w_wrap;
    logic [CH_BITS-1:0]  w_sel;
    logic [CH_BITS-1:0]  w_nxt;

    // Output handshake: a result transfers on any clk edge where out_valid && out_ready;
    // the register reloads only when empty or transferring, so outputs hold while stalled.
    assign w_load    = !r_out_valid || out_ready;
    assign w_capture = {CHANNELS{en}} & r_tog_evt & r_armed;

    always_comb begin
        w_rot   = CHANNELS'({r_pending, r_pending} >> r_rr_ptr);
        w_found = 1'b0;
        w_off   = '0;
        // Descending scan leaves the lowest offset from rr_ptr as the winner.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = CH_BITS'(k);
            end
        end
        w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_wrap = (w_sum >= CH_CNT) ? (w_sum - CH_CNT) : w_sum;
        w_sel  = w_wrap[CH_BITS-1:0];
        w_nxt  = (({1'b0, w_sel} + 1'b1) == CH_CNT) ? '0 : (w_sel + 1'b1);
        w_take = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (w_load && w_found && (w_sel == CH_BITS'(ch))) w_take[ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_tog <= '0;
            r_tog_evt  <= '0;
            r_sat      <= '0;
            r_armed    <= '0;
            r_pending  <= '0;
            r_hold_sat <= '0;
            r_overrun  <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_acc[ch]    <= '0;
                r_hold_w[ch] <= '0;
`ifdef PWM_CAPTURE_PERIOD_EN
                r_per[ch]     <= '0;
                r_hold_p[ch]  <= '0;
                r_per_sat[ch] <= 1'b0;
`endif
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_last_tog[ch] <= toggle_in[ch];
                r_tog_evt[ch]  <= toggle_in[ch] ^ r_last_tog[ch];
                if (en) begin
                    if (r_tog_evt[ch]) begin
                        // The first event after reset closes a partial window: arm only.
                        if (r_armed[ch]) begin
                            r_hold_w[ch] <= r_acc[ch];
`ifdef PWM_CAPTURE_PERIOD_EN
                            r_hold_p[ch]   <= r_per[ch];
                            r_hold_sat[ch] <= r_sat[ch] | r_per_sat[ch];
`else
                            r_hold_sat[ch] <= r_sat[ch];
`endif
                        end
                        r_acc[ch]   <= CNT_BITS'(pwm_in[ch]);
                        r_sat[ch]   <= 1'b0;
                        r_armed[ch] <= 1'b1;
`ifdef PWM_CAPTURE_PERIOD_EN
                        r_per[ch]     <= CNT_BITS'(1);
                        r_per_sat[ch] <= 1'b0;
`endif
                    end else begin
                        if (pwm_in[ch] && (r_acc[ch] != CNT_MAX)) r_acc[ch] <= r_acc[ch] + 1'b1;
                        if (pwm_in[ch] && (r_acc[ch] == CNT_MAX)) r_sat[ch] <= 1'b1;
`ifdef PWM_CAPTURE_PERIOD_EN
                        if (r_per[ch] != CNT_MAX) r_per[ch] <= r_per[ch] + 1'b1;
                        else                      r_per_sat[ch] <= 1'b1;
`endif
                    end
                end
                if (w_capture[ch])   r_pending[ch] <= 1'b1;
                else if (w_take[ch]) r_pending[ch] <= 1'b0;
                // A same-cycle take drains the old hold, so the new capture is not an overrun.
                r_overrun[ch] <= (r_overrun[ch] & ~clear_overrun)
                               | (w_capture[ch] & r_pending[ch] & ~w_take[ch]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_out_width <= '0;
            r_out_sat   <= 1'b0;
            r_rr_ptr    <= '0;
`ifdef PWM_CAPTURE_PERIOD_EN
            r_out_period <= '0;
`endif
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_chan  <= w_sel;
                r_out_width <= r_hold_w[w_sel];
                r_out_sat   <= r_hold_sat[w_sel];
                r_rr_ptr    <= w_nxt;
`ifdef PWM_CAPTURE_PERIOD_EN
                r_out_period <= r_hold_p[w_sel];
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign out_width = r_out_width;
    assign out_sat   = r_out_sat;
    assign overrun   = r_overrun;
`ifdef PWM_CAPTURE_PERIOD_EN
    assign out_period = r_out_period;
`endif

endmodule

// File: tb/tb_pwm_width_capture.sv
// Directed bench for pwm_width_capture: window table on channel 0 plus hand-written
// sequences for latency, round-robin, backpressure/overrun, enable gating and reset.
`timescale 1ns/1ps

module tb_pwm_width_capture;

    localparam int CHANNELS = 2;
    localparam int CNT_BITS = 4;
    localparam int CH_BITS  = 1;
    localparam int RW       = CH_BITS + 1 + CNT_BITS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [CHANNELS-1:0] pwm_in;
    logic [CHANNELS-1:0] toggle_in;
    logic                out_valid;
    logic                out_ready;
    logic [CH_BITS-1:0]  out_chan;
    logic [CNT_BITS-1:0] out_width;
    logic                out_sat;
    logic [CHANNELS-1:0] overrun;
    logic                clear_overrun;
`ifdef PWM_CAPTURE_PERIOD_EN
    logic [CNT_BITS-1:0] out_period;
`endif

    pwm_width_capture #(
        .CHANNELS(CHANNELS),
        .CNT_BITS(CNT_BITS),
        .CH_BITS (CH_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pwm_in       (pwm_in),
        .toggle_in    (toggle_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_chan     (out_chan),
        .out_width    (out_width),
        .out_sat      (out_sat),
`ifdef PWM_CAPTURE_PERIOD_EN
        .out_period   (out_period),
`endif
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    typedef struct {
        int                  len;
        int                  high;
        logic [CNT_BITS-1:0] exp_w;
        logic                exp_s;
    } win_vec_t;

    win_vec_t vecs[12];

    // Log every accepted result, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_chan, out_sat, out_width});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Window occupies len cycles; pwm high for the first high cycles; toggle flips on the last.
    task automatic run_window(input int len, input int high0, input int high1, input logic [1:0] tmask);
        for (int i = 0; i < len; i++) begin
            pwm_in[0] = (i < high0);
            pwm_in[1] = (i < high1);
            if (i == len - 1) toggle_in = toggle_in ^ tmask;
            step();
        end
        pwm_in = '0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        en            = 1'b1;
        out_ready     = 1'b1;
        clear_overrun = 1'b0;
        pwm_in        = '0;
        toggle_in     = '0;
        step();
        step();
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_got(input string name);
        logic [RW-1:0] g;
        logic [RW-1:0] e;
        check({name, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check(name, g, e);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0]  = '{8,  5,  4'd5,  1'b0};
        vecs[1]  = '{8,  5,  4'd5,  1'b0};
        vecs[2]  = '{20, 20, 4'd15, 1'b1};
        vecs[3]  = '{10, 10, 4'd10, 1'b0};
        vecs[4]  = '{15, 15, 4'd15, 1'b0};
        vecs[5]  = '{16, 16, 4'd15, 1'b1};
        vecs[6]  = '{12, 0,  4'd0,  1'b0};
        vecs[7]  = '{7,  3,  4'd3,  1'b0};
        vecs[8]  = '{1,  1,  4'd1,  1'b0};
        vecs[9]  = '{1,  0,  4'd0,  1'b0};
        vecs[10] = '{1,  1,  4'd1,  1'b0};
        vecs[11] = '{3,  2,  4'd2,  1'b0};

        // Reset state
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_chan", out_chan, 0);
        check("rst_width", out_width, 0);
        check("rst_sat", out_sat, 0);
        check("rst_overrun", overrun, 0);

        // First-result latency and the 5-of-8 pattern
        run_window(4, 0, 0, 2'b01);
        run_window(8, 5, 0, 2'b01);
        check("lat_t1", out_valid, 0);
        step();
        check("lat_t2", out_valid, 0);
        step();
        check("lat_t3_valid", out_valid, 1);
        check("lat_t3_width", out_width, 5);
        check("lat_t3_chan", out_chan, 0);
        check("lat_t3_sat", out_sat, 0);
        exp_q.push_back({1'b0, 1'b0, 4'd5});
        run_window(8, 5, 0, 2'b01);
        exp_q.push_back({1'b0, 1'b0, 4'd5});
        run_window(8, 5, 0, 2'b01);
        exp_q.push_back({1'b0, 1'b0, 4'd5});
        idle(5);
        check_got("pattern58");

        // Window table on channel 0, including saturation boundaries and 1-cycle windows
        do_reset();
        run_window(4, 0, 0, 2'b01);
        for (int i = 0; i < 12; i++) begin
            run_window(vecs[i].len, vecs[i].high, 0, 2'b01);
            exp_q.push_back({1'b0, vecs[i].exp_s, vecs[i].exp_w});
        end
        idle(5);
        check_got("table");
        check("table_overrun", overrun, 0);

        // Simultaneous toggles: round-robin ch0 then ch1, twice
        do_reset();
        run_window(4, 0, 0, 2'b11);
        run_window(6, 3, 4, 2'b11);
        step();
        step();
        check("rr1_ch0_valid", out_valid, 1);
        check("rr1_ch0_chan", out_chan, 0);
        check("rr1_ch0_width", out_width, 3);
        step();
        check("rr1_ch1_chan", out_chan, 1);
        check("rr1_ch1_width", out_width, 4);
        step();
        check("rr1_idle_valid", out_valid, 0);
        run_window(5, 2, 5, 2'b11);
        step();
        step();
        check("rr2_ch0_chan", out_chan, 0);
        check("rr2_ch0_width", out_width, 2);
        step();
        check("rr2_ch1_chan", out_chan, 1);
        check("rr2_ch1_width", out_width, 5);
        step();
        check("rr2_idle_valid", out_valid, 0);

        // Backpressure across three windows: stable output, overrun, latest window kept
        do_reset();
        run_window(4, 0, 0, 2'b01);
        out_ready = 1'b0;
        run_window(6, 2, 0, 2'b01);
        step();
        step();
        check("bp_w1_valid", out_valid, 1);
        check("bp_w1_width", out_width, 2);
        run_window(6, 4, 0, 2'b01);
        step();
        step();
        check("bp_w2_valid", out_valid, 1);
        check("bp_w2_width", out_width, 2);
        check("bp_w2_overrun", overrun, 0);
        run_window(6, 5, 0, 2'b01);
        step();
        step();
        check("bp_w3_valid", out_valid, 1);
        check("bp_w3_width", out_width, 2);
        check("bp_w3_chan", out_chan, 0);
        check("bp_w3_overrun", overrun, 2'b01);
        got_q.delete();
        exp_q.push_back({1'b0, 1'b0, 4'd2});
        exp_q.push_back({1'b0, 1'b0, 4'd5});
        out_ready = 1'b1;
        idle(4);
        check_got("bp_drain");
        check("bp_sticky", overrun, 2'b01);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("bp_cleared", overrun, 0);

        // Enable low across a toggle: event lost, count resumes
        do_reset();
        run_window(4, 0, 0, 2'b01);
        pwm_in[0] = 1'b1;
        idle(4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) toggle_in[0] = ~toggle_in[0];
            step();
        end
        check("en_off_valid", out_valid, 0);
        en = 1'b1;
        run_window(3, 3, 0, 2'b01);
        check("en_t1_valid", out_valid, 0);
        step();
        check("en_t2_valid", out_valid, 0);
        step();
        check("en_t3_valid", out_valid, 1);
        check("en_t3_width", out_width, 7);
        check("en_t3_sat", out_sat, 0);
        got_q.delete();

        // Reset mid-window with output held, data pending and overrun set
        do_reset();
        run_window(4, 0, 0, 2'b01);
        out_ready = 1'b0;
        run_window(5, 3, 0, 2'b01);
        step();
        step();
        check("mr_pre_width", out_width, 3);
        run_window(5, 2, 0, 2'b01);
        run_window(5, 1, 0, 2'b01);
        step();
        check("mr_pre_overrun", overrun, 2'b01);
        pwm_in[0] = 1'b1;
        idle(2);
        rst_n     = 1'b0;
        pwm_in    = '0;
        toggle_in = '0;
        step();
        check("mr_valid", out_valid, 0);
        check("mr_chan", out_chan, 0);
        check("mr_width", out_width, 0);
        check("mr_sat", out_sat, 0);
        check("mr_overrun", overrun, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        exp_q.delete();
        run_window(5, 5, 0, 2'b01);
        idle(4);
        check("mr_discard_valid", out_valid, 0);
        run_window(6, 4, 0, 2'b01);
        exp_q.push_back({1'b0, 1'b0, 4'd4});
        idle(5);
        check_got("mr_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
